// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and frame/strobe output bundle of the UART frame parser.
// The parser takes the slave view; the byte source and frame consumer take the master view.
interface uart_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [47:0] frame_data;
  logic        frame_valid;
  logic        chk_err;
  logic        timeout_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  frame_data, frame_valid, chk_err, timeout_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output frame_data, frame_valid, chk_err, timeout_err, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SYNC + 6 payload + XOR-checksum frames from a UART byte stream and
// reports each frame as a one-cycle payload strobe, checksum error or timeout error.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 57320,
  parameter int unsigned TO_W        = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_parser_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  function automatic logic [7:0] f_chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_cnt;
  logic [47:0]     r_shift;
  logic [7:0]      r_acc;
  logic [TO_W-1:0] r_to_cnt;
  logic [47:0]     r_frame_data;
  logic            r_frame_valid;
  logic            r_chk_err;
  logic            r_timeout_err;
  logic            r_busy;
  logic            w_to_hit;
  logic            w_fv_nx;
  logic            w_ce_nx;
  logic            w_to_nx;

  // An arriving byte always beats the timeout in the same cycle.
  assign w_to_hit = (r_state != S_IDLE) && !bus.rx_valid && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) w_next_state = S_PAYLOAD;
        else                                             w_next_state = S_IDLE;
      end
      S_PAYLOAD: begin
        if (w_to_hit)                              w_next_state = S_IDLE;
        else if (bus.rx_valid && (r_cnt == 3'd5))  w_next_state = S_CHECK;
        else                                       w_next_state = S_PAYLOAD;
      end
      S_CHECK: begin
        if (w_to_hit || bus.rx_valid) w_next_state = S_IDLE;
        else                          w_next_state = S_CHECK;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobe decode, registered below.
  always_comb begin
    w_fv_nx = 1'b0;
    w_ce_nx = 1'b0;
    w_to_nx = w_to_hit;
    if ((r_state == S_CHECK) && bus.rx_valid) begin
      if (bus.rx_data == r_acc) w_fv_nx = 1'b1;
      else                      w_ce_nx = 1'b1;
    end else begin
      w_fv_nx = 1'b0;
      w_ce_nx = 1'b0;
    end
  end

  // Byte count, payload shift register, checksum accumulator and inter-byte timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 3'd0;
      r_shift  <= 48'h0;
      r_acc    <= 8'h00;
      r_to_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) || bus.rx_valid || w_to_hit) r_to_cnt <= '0;
      else                                                r_to_cnt <= r_to_cnt + TO_W'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            r_cnt <= 3'd0;
            r_acc <= 8'h00;
          end
        end
        S_PAYLOAD: begin
          if (bus.rx_valid) begin
            r_shift <= {r_shift[39:0], bus.rx_data};
            r_acc   <= f_chk_add(r_acc, bus.rx_data);
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; frame_data only moves on a good checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_data  <= 48'h0;
      r_frame_valid <= 1'b0;
      r_chk_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_fv_nx) r_frame_data <= r_shift;
      r_frame_valid <= w_fv_nx;
      r_chk_err     <= w_ce_nx;
      r_timeout_err <= w_to_nx;
      r_busy        <= (w_next_state != S_IDLE);
    end
  end

  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.chk_err     = r_chk_err;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = r_busy;

endmodule
